// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the instruction-fetch front end:
//   - seq_state_e    : fetch sequencer states
//   - redirect_sel_e : which next-PC source the redirect logic picked
//   - RESET_PC_DEFAULT : word-aligned PC loaded on reset
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALT
  } seq_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR
  } redirect_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Groups the instruction-memory request bus and the decode-side
// instruction handshake.
//   imem_req/imem_addr  : fetch request and address (sequencer -> memory)
//   imem_ack/imem_data  : fetch completion and word (memory -> sequencer)
//   inst/inst_pc/inst_valid : registered instruction (sequencer -> decode)
//   stall               : decode not ready (decode -> sequencer)
// master = the fetch sequencer, slave = memory/decode environment.
interface pc_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        stall;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid,
    input  imem_ack, imem_data, stall
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid,
    output imem_ack, imem_data, stall
  );

endinterface

// File: rtl/next_pc_calc.sv
// next_pc_calc
// Combinational redirect target and source select for the instruction
// currently held in the output register.
//   inst_pc                  : address of that instruction
//   branch_taken/branch_addr : conditional branch, sign-extended word offset
//   jump/jump_addr           : J/JAL, 26-bit target already shifted by 2
//   jr/jr_target             : register-indirect target
//   target                   : selected redirect address
//   sel                      : SEL_SEQ when nothing redirects
// Priority is jr over jump over branch.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic          [31:0] inst_pc,
  input  logic                 branch_taken,
  input  logic          [31:0] branch_addr,
  input  logic                 jump,
  input  logic          [27:0] jump_addr,
  input  logic                 jr,
  input  logic          [31:0] jr_target,
  output logic          [31:0] target,
  output redirect_sel_e        sel
);

  logic [31:0] p4;

  assign p4 = inst_pc + 32'd4;

  always_comb begin
    sel    = SEL_SEQ;
    target = p4;
    if (jr) begin
      sel    = SEL_JR;
      target = jr_target;
    end else if (jump) begin
      // Region bits come from the delay-slot-free successor address.
      sel    = SEL_J;
      target = {p4[31:28], jump_addr};
    end else if (branch_taken) begin
      sel    = SEL_BR;
      target = p4 + (branch_addr << 2);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Instruction-fetch controller: owns the PC, issues one instruction-memory
// request at a time and hands one registered instruction to decode.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : run enable; dropping it stops fetching after the
//                  outstanding request completes
//   branch_taken, branch_addr, jump, jump_addr, jr, jr_target :
//                  redirect controls for the instruction in bus.inst
//   pc           : address of the next fetch
//   misaligned   : sticky, set by a jr to an unaligned target
//   bus          : memory request bus and decode handshake (master side)
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        jump,
  input  logic [27:0] jump_addr,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic        misaligned,
  pc_sequencer_if.master bus
);

  seq_state_e    state_q, state_d, after_fetch;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   inst_pc_q, inst_pc_d;
  logic          inst_valid_q, inst_valid_d;
  logic [31:0]   skid_data_q, skid_data_d;
  logic [31:0]   skid_pc_q, skid_pc_d;
  logic          squash_q, squash_d;
  logic [31:0]   squash_addr_q, squash_addr_d;
  logic          misaligned_q, misaligned_d;

  logic [31:0]   target;
  redirect_sel_e sel;
  logic          fire;
  logic          redirect;
  logic          bad_jr;

  next_pc_calc u_next_pc_calc (
    .inst_pc      (inst_pc_q),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .jr           (jr),
    .jr_target    (jr_target),
    .target       (target),
    .sel          (sel)
  );

  // Redirect controls only mean something for an instruction being consumed.
  assign fire     = inst_valid_q && !bus.stall;
  assign redirect = fire && (sel != SEL_SEQ);
  assign bad_jr   = redirect && (sel == SEL_JR) && (target[1:0] != 2'b00);

  assign bus.imem_req   = (state_q == REQ);
  // A squashed request keeps its original address until its ack, even
  // though pc has already moved to the redirect target.
  assign bus.imem_addr  = squash_q ? squash_addr_q : pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign pc             = pc_q;
  assign misaligned     = misaligned_q;

  assign after_fetch = en ? REQ : IDLE;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q && bus.stall;
    skid_data_d   = skid_data_q;
    skid_pc_d     = skid_pc_q;
    squash_d      = squash_q;
    squash_addr_d = squash_addr_q;
    misaligned_d  = misaligned_q | bad_jr;

    if (redirect) begin
      pc_d = target;
    end

    case (state_q)
      IDLE: begin
        if (bad_jr) begin
          state_d = HALT;
        end else if (en) begin
          state_d = REQ;
        end
      end

      REQ: begin
        if (squash_q) begin
          // The word of a killed request is dropped; pc already holds the target.
          if (bus.imem_ack) begin
            squash_d = 1'b0;
            state_d  = misaligned_q ? HALT : after_fetch;
          end
        end else if (redirect) begin
          if (bus.imem_ack) begin
            state_d = bad_jr ? HALT : after_fetch;
          end else begin
            squash_d      = 1'b1;
            squash_addr_d = pc_q;
          end
        end else if (bus.imem_ack) begin
          pc_d = pc_q + 32'd4;
          if (!inst_valid_q || !bus.stall) begin
            inst_d       = bus.imem_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = after_fetch;
          end else begin
            skid_data_d = bus.imem_data;
            skid_pc_d   = pc_q;
            state_d     = HOLD;
          end
        end
      end

      HOLD: begin
        // inst_valid is always set here, so !stall means the output is consumed.
        if (!bus.stall) begin
          if (redirect) begin
            state_d = bad_jr ? HALT : after_fetch;
          end else begin
            inst_d       = skid_data_q;
            inst_pc_d    = skid_pc_q;
            inst_valid_d = 1'b1;
            state_d      = after_fetch;
          end
        end
      end

      HALT: begin
        inst_valid_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inst_q        <= 32'h0;
      inst_pc_q     <= 32'h0;
      inst_valid_q  <= 1'b0;
      skid_data_q   <= 32'h0;
      skid_pc_q     <= 32'h0;
      squash_q      <= 1'b0;
      squash_addr_q <= 32'h0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      skid_data_q   <= skid_data_d;
      skid_pc_q     <= skid_pc_d;
      squash_q      <= squash_d;
      squash_addr_q <= squash_addr_d;
      misaligned_q  <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Bench for pc_sequencer: directed timing scenarios followed by a random
// phase. The random phase checks every consumed instruction against an
// architectural program-flow model: the next delivered instruction is the
// redirect target if the consumed one redirected, else its address + 4.
// Memory returns memWord(addr) after a fixed or random number of wait states.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk;
  logic        rst;
  logic        en;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        jump;
  logic [27:0] jump_addr;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic        misaligned;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .jr           (jr),
    .jr_target    (jr_target),
    .pc           (pc),
    .misaligned   (misaligned),
    .bus          (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory model: word content is a fixed function of the address.
  int fixed_wait = 0;
  int cur_rand   = 0;
  int wait_cnt   = 0;
  logic rand_mode = 1'b0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_A5A5;
  endfunction

  assign bus.imem_ack  = bus.imem_req && (wait_cnt >= (rand_mode ? cur_rand : fixed_wait));
  assign bus.imem_data = memWord(bus.imem_addr);

  always @(posedge clk) begin
    if (bus.imem_req && !bus.imem_ack) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
    if (bus.imem_ack) begin
      cur_rand <= int'($urandom_range(0, 2));
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic bt, input logic [31:0] ba,
                               input logic j, input logic [27:0] ja,
                               input logic r, input logic [31:0] rt);
    bus.stall    = s;
    branch_taken = bt;
    branch_addr  = ba;
    jump         = j;
    jump_addr    = ja;
    jr           = r;
    jr_target    = rt;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] br_off;
  logic [31:0] rnd;
  logic [27:0] ja;
  logic [15:0] off16;
  logic        rnd_stall;
  logic        found;
  int          kind;
  int          delivered;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 28'h0, 0, 32'h0);
    stepCycle();
    stepCycle();

    // Reset state
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_addr", bus.imem_addr, RESET_PC);
    checkOutput("rst_req", bus.imem_req, 0);
    checkOutput("rst_valid", bus.inst_valid, 0);
    checkOutput("rst_inst", bus.inst, 0);
    checkOutput("rst_inst_pc", bus.inst_pc, 0);
    checkOutput("rst_misaligned", misaligned, 0);

    // Start with zero-wait memory
    rst = 1'b0;
    en  = 1'b1;
    stepCycle();
    checkOutput("c1_req", bus.imem_req, 1);
    checkOutput("c1_addr", bus.imem_addr, 32'h0040_0000);
    checkOutput("c1_valid", bus.inst_valid, 0);
    stepCycle();
    checkOutput("c2_valid", bus.inst_valid, 1);
    checkOutput("c2_inst_pc", bus.inst_pc, 32'h0040_0000);
    checkOutput("c2_inst", bus.inst, memWord(32'h0040_0000));
    checkOutput("c2_addr", bus.imem_addr, 32'h0040_0004);
    stepCycle();
    checkOutput("c3_inst_pc", bus.inst_pc, 32'h0040_0004);
    checkOutput("c3_addr", bus.imem_addr, 32'h0040_0008);

    // Backward branch at 0x00400010
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.inst_valid && bus.inst_pc == 32'h0040_0010) found = 1'b1;
      else stepCycle();
    end
    checkOutput("br_reached", found, 1);
    checkOutput("br_inflight_addr", bus.imem_addr, 32'h0040_0014);
    applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 28'h0, 0, 32'h0);
    stepCycle();
    applyStimulus(0, 0, 32'h0, 0, 28'h0, 0, 32'h0);
    checkOutput("br_target_addr", bus.imem_addr, 32'h0040_0004);
    checkOutput("br_bubble", bus.inst_valid, 0);
    stepCycle();
    checkOutput("br_valid", bus.inst_valid, 1);
    checkOutput("br_inst_pc", bus.inst_pc, 32'h0040_0004);

    // jr (with jump also raised) to the top of the 256MB region
    applyStimulus(0, 0, 32'h0, 1, 28'h000_0040, 1, 32'h0FFF_FFFC);
    stepCycle();
    applyStimulus(0, 0, 32'h0, 0, 28'h0, 0, 32'h0);
    checkOutput("jr_addr", bus.imem_addr, 32'h0FFF_FFFC);
    checkOutput("jr_pc", pc, 32'h0FFF_FFFC);
    checkOutput("jr_bubble", bus.inst_valid, 0);
    stepCycle();
    checkOutput("jr_inst_pc", bus.inst_pc, 32'h0FFF_FFFC);

    // Jump (with branch also raised): region bits come from p4
    applyStimulus(0, 1, 32'h0000_0010, 1, 28'h000_0100, 0, 32'h0);
    stepCycle();
    applyStimulus(0, 0, 32'h0, 0, 28'h0, 0, 32'h0);
    checkOutput("j_addr", bus.imem_addr, 32'h1000_0100);
    stepCycle();
    checkOutput("j_inst_pc", bus.inst_pc, 32'h1000_0100);
    checkOutput("j_inst", bus.inst, memWord(32'h1000_0100));

    // Three-cycle stall during the zero-wait stream
    applyStimulus(1, 0, 32'h0, 0, 28'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("stall_req", bus.imem_req, 0);
      checkOutput("stall_valid", bus.inst_valid, 1);
      checkOutput("stall_inst_pc", bus.inst_pc, 32'h1000_0100);
      checkOutput("stall_inst", bus.inst, memWord(32'h1000_0100));
    end
    applyStimulus(0, 0, 32'h0, 0, 28'h0, 0, 32'h0);
    stepCycle();
    checkOutput("skid_inst_pc", bus.inst_pc, 32'h1000_0104);
    checkOutput("skid_inst", bus.inst, memWord(32'h1000_0104));
    checkOutput("skid_req", bus.imem_req, 1);
    checkOutput("skid_addr", bus.imem_addr, 32'h1000_0108);
    stepCycle();
    checkOutput("resume_inst_pc_a", bus.inst_pc, 32'h1000_0108);
    stepCycle();
    checkOutput("resume_inst_pc_b", bus.inst_pc, 32'h1000_010C);

    // en falls with a request completing this cycle
    en = 1'b0;
    stepCycle();
    checkOutput("en_off_inst_pc", bus.inst_pc, 32'h1000_0110);
    checkOutput("en_off_req", bus.imem_req, 0);
    checkOutput("en_off_pc", pc, 32'h1000_0114);
    stepCycle();
    checkOutput("en_off_drained", bus.inst_valid, 0);
    checkOutput("en_off_req_idle", bus.imem_req, 0);
    en = 1'b1;
    stepCycle();
    checkOutput("en_on_req", bus.imem_req, 1);
    checkOutput("en_on_addr", bus.imem_addr, 32'h1000_0114);

    // Misaligned jr while a 2-wait-state fetch is outstanding
    rst = 1'b1;
    stepCycle();
    fixed_wait = 2;
    rst = 1'b0;
    en  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.inst_valid && bus.imem_req && !bus.imem_ack) found = 1'b1;
      else stepCycle();
    end
    checkOutput("mis_reached", found, 1);
    checkOutput("mis_setup_inst_pc", bus.inst_pc, 32'h0040_0000);
    checkOutput("mis_setup_addr", bus.imem_addr, 32'h0040_0004);
    applyStimulus(0, 0, 32'h0, 0, 28'h0, 1, 32'h0040_0002);
    stepCycle();
    applyStimulus(0, 0, 32'h0, 0, 28'h0, 0, 32'h0);
    checkOutput("mis_flag", misaligned, 1);
    checkOutput("mis_valid", bus.inst_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      checkOutput("mis_req_held", bus.imem_req, 1);
      checkOutput("mis_addr_held", bus.imem_addr, 32'h0040_0004);
      if (bus.imem_ack) found = 1'b1;
      stepCycle();
    end
    checkOutput("mis_ack_seen", found, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("halt_req", bus.imem_req, 0);
      checkOutput("halt_valid", bus.inst_valid, 0);
      checkOutput("halt_misaligned", misaligned, 1);
      stepCycle();
    end

    // Reset asserted while a request waits for its ack
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.inst_valid && bus.imem_req && !bus.imem_ack && bus.inst_pc == 32'h0040_0004) found = 1'b1;
      else stepCycle();
    end
    checkOutput("rmid_reached", found, 1);
    checkOutput("rmid_pre_pc", pc, 32'h0040_0008);
    rst = 1'b1;
    #1;
    checkOutput("rmid_req", bus.imem_req, 0);
    checkOutput("rmid_pc", pc, RESET_PC);
    checkOutput("rmid_addr", bus.imem_addr, RESET_PC);
    checkOutput("rmid_valid", bus.inst_valid, 0);
    checkOutput("rmid_inst", bus.inst, 0);
    checkOutput("rmid_inst_pc", bus.inst_pc, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    rand_mode = 1'b1;
    stepCycle();
    checkOutput("rmid_first_req", bus.imem_req, 1);
    checkOutput("rmid_first_addr", bus.imem_addr, RESET_PC);

    // Random phase against the program-flow model
    exp_pc = RESET_PC;
    delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rnd_stall = ($urandom_range(0, 99) < 30);
      en = ($urandom_range(0, 99) < 90);
      if (bus.inst_valid && !rnd_stall) begin
        checkOutput("rnd_inst_pc", bus.inst_pc, exp_pc);
        checkOutput("rnd_inst", bus.inst, memWord(exp_pc));
        delivered++;
        kind  = int'($urandom_range(0, 9));
        off16 = 16'($urandom);
        br_off = {{16{off16[15]}}, off16};
        rnd = $urandom;
        ja = {rnd[25:0], 2'b00};
        case (kind)
          0, 1: begin
            applyStimulus(0, 1, br_off, 0, 28'h0, 0, 32'h0);
            exp_pc = exp_pc + 32'd4 + br_off * 32'd4;
          end
          2: begin
            applyStimulus(0, $urandom_range(0, 1) == 1, br_off, 1, ja, 0, 32'h0);
            exp_pc = ((exp_pc + 32'd4) & 32'hF000_0000) | {4'h0, ja};
          end
          3: begin
            applyStimulus(0, $urandom_range(0, 1) == 1, br_off, $urandom_range(0, 1) == 1, ja,
                          1, rnd & 32'hFFFF_FFFC);
            exp_pc = rnd & 32'hFFFF_FFFC;
          end
          default: begin
            applyStimulus(0, 0, br_off, 0, ja, 0, rnd);
            exp_pc = exp_pc + 32'd4;
          end
        endcase
      end else begin
        rnd = $urandom;
        applyStimulus(rnd_stall, rnd[0], $urandom, rnd[1], 28'($urandom), rnd[2], $urandom);
      end
      stepCycle();
    end
    en = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 28'h0, 0, 32'h0);
    checkOutput("rnd_progress", delivered >= 200, 1);
    checkOutput("rnd_misaligned", misaligned, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
